// File: rtl/ahbl_pkg.sv
// Shared AHB-lite encodings for the hazard5 test slave: transfer and size codes,
// wait-mode selects, data-phase state encoding and byte-lane helpers.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [1:0] WAIT_NONE  = 2'd0;
    localparam logic [1:0] WAIT_FIXED = 2'd1;
    localparam logic [1:0] WAIT_LFSR  = 2'd2;
    localparam logic [1:0] WAIT_EXT   = 2'd3;

    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

    function automatic logic trans_active(input logic [1:0] htrans);
        case (htrans)
            HTRANS_IDLE, HTRANS_BUSY: trans_active = 1'b0;
            HTRANS_NSEQ, HTRANS_SEQ:  trans_active = 1'b1;
            default:                  trans_active = 1'b0;
        endcase
    endfunction

    function automatic logic bad_access(input logic [2:0] hsize, input logic [1:0] lo);
        case (hsize)
            HSIZE_BYTE: bad_access = 1'b0;
            HSIZE_HALF: bad_access = lo[0];
            HSIZE_WORD: bad_access = (lo != 2'b00);
            default:    bad_access = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] lo);
        case (hsize)
            HSIZE_BYTE: lane_mask = 4'b0001 << lo;
            HSIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/hazard5_ahbl_test_slave_waitgen.sv
// Wait-state source for the test slave: free-running LFSR plus the mode mux
// and MAX_WAIT clamp that yield the wait count offered at address acceptance.
module hazard5_ahbl_waitgen
    import ahbl_pkg::*;
#(
    parameter int          MAX_WAIT  = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] cfg_wait_mode,
    input  logic [3:0] cfg_wait_fixed,
    output logic [3:0] wait_n,
    output logic       wait_ext
);

    localparam logic [3:0] MAX_N = 4'(MAX_WAIT);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    function automatic logic [3:0] clamp(input logic [3:0] v);
        return (v > MAX_N) ? MAX_N : v;
    endfunction

    assign lfsr_next = (lfsr_reg >> 1) ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    always_comb begin
        wait_n   = 4'd0;
        wait_ext = 1'b0;
        case (cfg_wait_mode)
            WAIT_NONE:  wait_n = 4'd0;
            WAIT_FIXED: wait_n = clamp(cfg_wait_fixed);
            WAIT_LFSR:  wait_n = clamp(lfsr_reg[3:0]);
            WAIT_EXT:   wait_ext = 1'b1;
            default:    wait_n = 4'd0;
        endcase
    end

endmodule

// File: rtl/hazard5_ahbl_test_slave.sv
// AHB-lite test slave: word memory with byte-lane writes, programmable wait
// states, an address error window and completion counters.
module hazard5_ahbl_test_slave
    import ahbl_pkg::*;
#(
    parameter int          W_ADDR      = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          MAX_WAIT    = 7,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [W_ADDR-1:0] ahbls_haddr,
    input  logic              ahbls_hwrite,
    input  logic [1:0]        ahbls_htrans,
    input  logic [2:0]        ahbls_hsize,
    input  logic [31:0]       ahbls_hwdata,
    input  logic              ahbls_hready,
    input  logic              ahbls_hsel,
    output logic              ahbls_hready_resp,
    output logic              ahbls_hresp,
    output logic [31:0]       ahbls_hrdata,
    input  logic [1:0]        cfg_wait_mode,
    input  logic [3:0]        cfg_wait_fixed,
    input  logic              ext_ready,
    input  logic [W_ADDR-1:0] cfg_err_base,
    input  logic [W_ADDR-1:0] cfg_err_mask,
    output logic [15:0]       stat_xfer_count,
    output logic [15:0]       stat_err_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    slave_state_t     state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg;
    logic             wr_reg;
    logic [3:0]       mask_reg;
    logic             ext_reg;
    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      rdata_reg;
    logic             fwd_hit_reg;
    logic [3:0]       fwd_mask_reg;
    logic [31:0]      fwd_data_reg;
    logic [15:0]      xfer_reg, err_reg;

    logic [3:0]       wait_n;
    logic             wait_ext;
    logic [IDX_W-1:0] addr_idx;
    logic             in_window, addr_err, accept, launch;
    logic             resp_cycle, wr_commit, rd_resp;

    hazard5_ahbl_waitgen #(
        .MAX_WAIT  (MAX_WAIT),
        .LFSR_SEED (LFSR_SEED)
    ) u_waitgen (
        .clock          (clock),
        .reset          (reset),
        .cfg_wait_mode  (cfg_wait_mode),
        .cfg_wait_fixed (cfg_wait_fixed),
        .wait_n         (wait_n),
        .wait_ext       (wait_ext)
    );

    assign addr_idx  = ahbls_haddr[IDX_W+1:2];
    assign in_window = (cfg_err_mask != '0) &&
                       ((ahbls_haddr & cfg_err_mask) == (cfg_err_base & cfg_err_mask));
    assign addr_err  = in_window || bad_access(ahbls_hsize, ahbls_haddr[1:0]);

    // External-ready WAIT doubles as the RESP cycle once ext_ready rises
    assign resp_cycle = (state_reg == ST_RESP) ||
                        ((state_reg == ST_WAIT) && ext_reg && ext_ready);
    assign wr_commit  = resp_cycle && wr_reg && !reset;
    assign rd_resp    = resp_cycle && !wr_reg;

    always_comb begin
        ahbls_hready_resp = 1'b1;
        ahbls_hresp       = 1'b0;
        case (state_reg)
            ST_WAIT: ahbls_hready_resp = ext_reg && ext_ready;
            ST_ERR1: begin
                ahbls_hready_resp = 1'b0;
                ahbls_hresp       = 1'b1;
            end
            ST_ERR2: ahbls_hresp = 1'b1;
            default: ahbls_hready_resp = 1'b1;
        endcase
    end

    assign accept = ahbls_hsel && ahbls_hready && trans_active(ahbls_htrans) &&
                    ahbls_hready_resp;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        launch     = 1'b0;
        case (state_reg)
            ST_WAIT: begin
                if (ext_reg) begin
                    launch = ext_ready;
                end else if (cnt_reg <= 4'd1) begin
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: launch = 1'b1;
        endcase
        if (launch) begin
            if (!accept) begin
                state_next = ST_IDLE;
            end else if (addr_err) begin
                state_next = ST_ERR1;
            end else if (wait_ext) begin
                state_next = ST_WAIT;
            end else if (wait_n != 4'd0) begin
                state_next = ST_WAIT;
                cnt_next   = wait_n;
            end else begin
                state_next = ST_RESP;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 4'd0;
            idx_reg      <= '0;
            wr_reg       <= 1'b0;
            mask_reg     <= 4'd0;
            ext_reg      <= 1'b0;
            fwd_hit_reg  <= 1'b0;
            fwd_mask_reg <= 4'd0;
            fwd_data_reg <= 32'd0;
            xfer_reg     <= 16'd0;
            err_reg      <= 16'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                idx_reg  <= addr_idx;
                wr_reg   <= ahbls_hwrite;
                mask_reg <= lane_mask(ahbls_hsize, ahbls_haddr[1:0]);
                ext_reg  <= wait_ext;
                // The memory read below sees the pre-write word when the
                // previous write lands on the same edge; remember its lanes.
                fwd_hit_reg  <= wr_commit && (idx_reg == addr_idx);
                fwd_mask_reg <= mask_reg;
                fwd_data_reg <= ahbls_hwdata;
            end
            if (resp_cycle) begin
                xfer_reg <= xfer_reg + 16'd1;
            end
            if (state_reg == ST_ERR2) begin
                err_reg <= err_reg + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_reg[i]) begin
                    mem[idx_reg][i*8 +: 8] <= ahbls_hwdata[i*8 +: 8];
                end
            end
        end
        if (accept) begin
            rdata_reg <= mem[addr_idx];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign ahbls_hrdata[gi*8 +: 8] =
                !rd_resp                          ? 8'h00 :
                (fwd_hit_reg && fwd_mask_reg[gi]) ? fwd_data_reg[gi*8 +: 8] :
                                                    rdata_reg[gi*8 +: 8];
        end
    endgenerate

    assign stat_xfer_count = xfer_reg;
    assign stat_err_count  = err_reg;

endmodule
